// File: rtl/stream_asyn_fifo_write_v2_if.sv
// Write-side bundle of the framed async stream FIFO.
// The source drives commands and the synchronised read pointer; the controller drives RAM and status.
interface stream_asyn_fifo_write_v2_if #(
  parameter int AW = 6
);
  logic [2:0]    w_cmd;
  logic [AW:0]   r2w_ptr;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [AW:0]   wptr;
  logic          w_full;
  logic          w_afull;
  logic [AW:0]   w_level;
  logic [AW:0]   w_frame_len;
  logic          w_drop;
  logic          w_error;

  modport master (
    output w_cmd, r2w_ptr,
    input  w_addr, w_we, wptr, w_full, w_afull, w_level, w_frame_len, w_drop, w_error
  );

  modport slave (
    input  w_cmd, r2w_ptr,
    output w_addr, w_we, wptr, w_full, w_afull, w_level, w_frame_len, w_drop, w_error
  );
endinterface

// File: rtl/stream_asyn_fifo_write_v2.sv
// Write-side controller of the framed async stream FIFO: tracks data/commit/head pointers over an
// even-depth pointer ring [MINB,MAXB] and publishes only committed frames as a Gray pointer.
//
//   state   | meaning
//   S_IDLE  | between frames, wp = sp + HEADSIZE
//   S_DATA  | collecting data words of a frame
//   S_HEADS | back-filling reserved head words at hp
//   S_DROP  | frame overflowed, swallowing words until EOF/DISCARD
module stream_asyn_fifo_write_v2 #(
  parameter int AW        = 6,
  parameter int DEPTH     = 44,
  parameter int HEADSIZE  = 0,
  parameter int AFULL_TH  = 40,
  parameter int AUTO_DROP = 1
) (
  input logic                       w_clk,
  input logic                       w_rst_n,
  stream_asyn_fifo_write_v2_if.slave bus
);
  localparam int MINB_I = (1 << AW) - DEPTH;
  localparam int MAXB_I = (1 << (AW + 1)) - 1 - MINB_I;
  localparam int SPAN_I = 2 * DEPTH;
  localparam int ERR_I  = DEPTH + HEADSIZE;
  localparam int WP0_I  = MINB_I + HEADSIZE;

  localparam logic [AW:0]   MINB    = MINB_I[AW:0];
  localparam logic [AW:0]   MAXB    = MAXB_I[AW:0];
  localparam logic [AW+1:0] SPAN    = SPAN_I[AW+1:0];
  localparam logic [AW:0]   MINB2   = {MINB[AW-1:0], 1'b0};
  localparam logic [AW:0]   HS      = HEADSIZE[AW:0];
  localparam logic [AW:0]   DEPTH_P = DEPTH[AW:0];
  localparam logic [AW:0]   AFULL_P = AFULL_TH[AW:0];
  localparam logic [AW:0]   ERR_TH  = ERR_I[AW:0];
  localparam logic [AW:0]   WP0     = WP0_I[AW:0];
  localparam logic [AW:0]   ONE     = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] C_WRITE = 3'd1;
  localparam logic [2:0] C_EOFW  = 3'd2;
  localparam logic [2:0] C_EOF   = 3'd3;
  localparam logic [2:0] C_HEAD  = 3'd4;
  localparam logic [2:0] C_HEADL = 3'd5;
  localparam logic [2:0] C_DISC  = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_HEADS = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  // Ring addition; k < DEPTH so a single fold back into [MINB,MAXB] suffices.
  function automatic logic [AW:0] ptr_add(input logic [AW:0] p, input logic [AW:0] k);
    logic [AW+1:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s > {1'b0, MAXB}) s = s - SPAN;
    return s[AW:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [AW:0] p);
    return p[AW] ? p[AW-1:0] : p[AW-1:0] - MINB[AW-1:0];
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   sp_q, sp_d;
  logic [AW:0]   hp_q, hp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   flen_q, flen_d;
  logic [AW:0]   wptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, afull_q, drop_q, err_q;

  logic          data_we, head_we, discard, cmd_err;
  logic          is_wr, is_eof, is_head;
  logic [AW:0]   rb, diff;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    sp_d    = sp_q;
    hp_d    = hp_q;
    addr_d  = addr_q;
    flen_d  = flen_q;
    data_we = 1'b0;
    head_we = 1'b0;
    discard = 1'b0;
    cmd_err = 1'b0;
    is_wr   = (bus.w_cmd == C_WRITE) || (bus.w_cmd == C_EOFW);
    is_eof  = (bus.w_cmd == C_EOFW) || (bus.w_cmd == C_EOF);
    is_head = (bus.w_cmd == C_HEAD) || (bus.w_cmd == C_HEADL);

    case (state_q)
      S_IDLE, S_DATA: begin
        if (is_wr && !full_q) begin
          data_we = 1'b1;
          wp_d    = ptr_add(wp_q, ONE);
          addr_d  = addr_of(wp_d);
          state_d = S_DATA;
          if (state_q == S_IDLE)      flen_d = ONE;
          else if (flen_q != DEPTH_P) flen_d = flen_q + ONE;
        end else if (is_wr) begin
          if (state_q == S_IDLE) flen_d = '0;
          state_d = (AUTO_DROP != 0) ? S_DROP : S_DATA;
        end else if (bus.w_cmd == C_EOF && state_q == S_IDLE) begin
          flen_d = '0;
        end
        // A blocked EOF_WRITE under auto-drop has nothing left to wait for: drop right away.
        if (is_eof && is_wr && full_q && AUTO_DROP != 0) begin
          discard = 1'b1;
        end else if (is_eof) begin
          if (HEADSIZE == 0) begin
            sp_d    = wp_d;
            state_d = S_IDLE;
          end else begin
            hp_d    = sp_q;
            addr_d  = addr_of(sp_q);
            state_d = S_HEADS;
          end
        end
      end
      S_HEADS: begin
        if (bus.w_cmd == C_HEAD) begin
          head_we = 1'b1;
          hp_d    = ptr_add(hp_q, ONE);
          addr_d  = addr_of(hp_d);
        end else if (bus.w_cmd == C_HEADL) begin
          head_we = 1'b1;
          sp_d    = wp_q;
          wp_d    = ptr_add(wp_q, HS);
          addr_d  = addr_of(wp_d);
          state_d = S_IDLE;
        end else if (is_wr || is_eof) begin
          cmd_err = 1'b1;
        end
      end
      default: begin
        if (is_eof) discard = 1'b1;
      end
    endcase

    if (bus.w_cmd == C_DISC) discard = 1'b1;
    if (discard) begin
      wp_d    = ptr_add(sp_q, HS);
      addr_d  = addr_of(wp_d);
      flen_d  = '0;
      state_d = S_IDLE;
    end
    if (bus.w_cmd == C_RSVD || (is_head && HEADSIZE == 0)) cmd_err = 1'b1;
  end

  // Modulo 2^(AW+1) the wrap case wp-rb-2*MINB equals wp-rb+2*DEPTH.
  always_comb begin
    rb = gray2bin(bus.r2w_ptr);
    if (wp_q >= rb) diff = wp_q - rb;
    else            diff = wp_q - rb - MINB2;
    level_d = diff + {{AW{1'b0}}, data_we};
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= S_IDLE;
      wp_q    <= WP0;
      sp_q    <= MINB;
      hp_q    <= MINB;
      addr_q  <= addr_of(WP0);
      flen_q  <= '0;
      wptr_q  <= bin2gray(MINB);
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      sp_q    <= sp_d;
      hp_q    <= hp_d;
      addr_q  <= addr_d;
      flen_q  <= flen_d;
      wptr_q  <= bin2gray(sp_q);
      level_q <= level_d;
      full_q  <= (level_d >= DEPTH_P);
      afull_q <= (level_d >= AFULL_P);
      drop_q  <= discard;
      err_q   <= err_q | cmd_err | (level_d > ERR_TH);
    end
  end

  assign bus.w_addr      = addr_q;
  assign bus.w_we        = data_we | head_we;
  assign bus.wptr        = wptr_q;
  assign bus.w_full      = full_q;
  assign bus.w_afull     = afull_q;
  assign bus.w_level     = level_q;
  assign bus.w_frame_len = flen_q;
  assign bus.w_drop      = drop_q;
  assign bus.w_error     = err_q;
endmodule

// File: tb/tb_stream_asyn_fifo_write_v2.sv
// Directed bench for the framed async FIFO write controller: one instance without head words
// (auto-drop) and one with two reserved head words.
module tb_stream_asyn_fifo_write_v2;
  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_WRITE = 3'd1;
  localparam logic [2:0] C_EOFW  = 3'd2;
  localparam logic [2:0] C_EOF   = 3'd3;
  localparam logic [2:0] C_HEAD  = 3'd4;
  localparam logic [2:0] C_HEADL = 3'd5;
  localparam logic [2:0] C_DISC  = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;

  logic w_clk;
  logic w_rst_n;
  int   checks = 0;
  int   errors = 0;

  stream_asyn_fifo_write_v2_if #(.AW(6)) if0 ();
  stream_asyn_fifo_write_v2_if #(.AW(6)) if2 ();

  stream_asyn_fifo_write_v2 #(.AW(6), .DEPTH(44), .HEADSIZE(0), .AFULL_TH(40), .AUTO_DROP(1)) u0 (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (if0)
  );

  stream_asyn_fifo_write_v2 #(.AW(6), .DEPTH(44), .HEADSIZE(2), .AFULL_TH(40), .AUTO_DROP(1)) u2 (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (if2)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [6:0] gray(input int p);
    logic [6:0] b;
    b = p[6:0];
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    w_rst_n = 1'b0;
    if0.w_cmd = C_NOP;
    if2.w_cmd = C_NOP;
    if0.r2w_ptr = gray(20);
    if2.r2w_ptr = gray(20);
    @(posedge w_clk); #1;
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
  endtask

  task automatic cyc0(input logic [2:0] c);
    if0.w_cmd = c;
    @(posedge w_clk); #1;
    if0.w_cmd = C_NOP;
  endtask

  task automatic cyc2(input logic [2:0] c);
    if2.w_cmd = c;
    @(posedge w_clk); #1;
    if2.w_cmd = C_NOP;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if0.w_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", if0.w_addr); end
    checks++; if (if0.wptr !== gray(20)) begin errors++; $display("FAIL reset_wptr: got %0d expected %0d", if0.wptr, gray(20)); end
    checks++; if ({if0.w_full, if0.w_afull, if0.w_drop, if0.w_error, if0.w_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {if0.w_full, if0.w_afull, if0.w_drop, if0.w_error, if0.w_we}); end
    checks++; if (if0.w_level !== 7'd0 || if0.w_frame_len !== 7'd0) begin
      errors++; $display("FAIL reset_counts: level %0d len %0d expected 0 0", if0.w_level, if0.w_frame_len); end
    checks++; if (if2.w_addr !== 6'd2) begin errors++; $display("FAIL reset_addr_hs2: got %0d expected 2", if2.w_addr); end
    checks++; if (if2.wptr !== gray(20)) begin errors++; $display("FAIL reset_wptr_hs2: got %0d expected %0d", if2.wptr, gray(20)); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if0.w_cmd = (i == 3) ? C_EOFW : C_WRITE;
      #1;
      checks++; if (if0.w_we !== 1'b1 || if0.w_addr !== i[5:0]) begin
        errors++; $display("FAIL basic_write%0d: we %b addr %0d expected we 1 addr %0d", i, if0.w_we, if0.w_addr, i); end
      @(posedge w_clk); #1;
    end
    if0.w_cmd = C_NOP;
    checks++; if (if0.w_level !== 7'd4) begin errors++; $display("FAIL basic_level: got %0d expected 4", if0.w_level); end
    checks++; if (if0.wptr !== gray(20)) begin errors++; $display("FAIL basic_wptr_early: got %0d expected %0d", if0.wptr, gray(20)); end
    checks++; if (if0.w_frame_len !== 7'd4) begin errors++; $display("FAIL basic_len: got %0d expected 4", if0.w_frame_len); end
    @(posedge w_clk); #1;
    checks++; if (if0.wptr !== gray(24)) begin errors++; $display("FAIL basic_wptr: got %0d expected %0d", if0.wptr, gray(24)); end
    checks++; if (if0.w_addr !== 6'd4) begin errors++; $display("FAIL basic_next_addr: got %0d expected 4", if0.w_addr); end
  endtask

  task automatic test_head_frame();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if2.w_cmd = C_WRITE;
      #1;
      checks++; if (if2.w_we !== 1'b1 || if2.w_addr !== 6'(i + 2)) begin
        errors++; $display("FAIL head_data%0d: we %b addr %0d expected we 1 addr %0d", i, if2.w_we, if2.w_addr, i + 2); end
      @(posedge w_clk); #1;
    end
    if2.w_cmd = C_EOF;
    #1;
    checks++; if (if2.w_we !== 1'b0) begin errors++; $display("FAIL head_eof_we: got %b expected 0", if2.w_we); end
    @(posedge w_clk); #1;
    for (int i = 0; i < 2; i++) begin
      if2.w_cmd = (i == 1) ? C_HEADL : C_HEAD;
      #1;
      checks++; if (if2.w_we !== 1'b1 || if2.w_addr !== i[5:0]) begin
        errors++; $display("FAIL head_word%0d: we %b addr %0d expected we 1 addr %0d", i, if2.w_we, if2.w_addr, i); end
      @(posedge w_clk); #1;
    end
    if2.w_cmd = C_NOP;
    checks++; if (if2.w_addr !== 6'd9) begin errors++; $display("FAIL head_next_addr: got %0d expected 9", if2.w_addr); end
    checks++; if (if2.wptr !== gray(20)) begin errors++; $display("FAIL head_wptr_early: got %0d expected %0d", if2.wptr, gray(20)); end
    @(posedge w_clk); #1;
    checks++; if (if2.wptr !== gray(27)) begin errors++; $display("FAIL head_wptr: got %0d expected %0d", if2.wptr, gray(27)); end
    checks++; if (if2.w_level !== 7'd9) begin errors++; $display("FAIL head_level: got %0d expected 9", if2.w_level); end
    checks++; if (if2.w_frame_len !== 7'd5 || if2.w_error !== 1'b0) begin
      errors++; $display("FAIL head_len_err: len %0d err %b expected 5 0", if2.w_frame_len, if2.w_error); end
  endtask

  task automatic test_wrap();
    int ptr;
    int idx;
    do_reset();
    ptr = 20;
    for (int f = 0; f < 10; f++) begin
      for (int j = 0; j < 10; j++) begin
        idx = (f * 10 + j) % 44;
        if0.w_cmd = (j == 9) ? C_EOFW : C_WRITE;
        #1;
        checks++; if (if0.w_we !== 1'b1 || if0.w_addr !== idx[5:0]) begin
          errors++; $display("FAIL wrap_addr f%0d w%0d: we %b addr %0d expected we 1 addr %0d", f, j, if0.w_we, if0.w_addr, idx); end
        @(posedge w_clk); #1;
      end
      if0.w_cmd = C_NOP;
      ptr = ptr + 10;
      if (ptr > 107) ptr = ptr - 88;
      @(posedge w_clk); #1;
      checks++; if (if0.wptr !== gray(ptr)) begin
        errors++; $display("FAIL wrap_wptr f%0d: got %0d expected %0d", f, if0.wptr, gray(ptr)); end
      if0.r2w_ptr = gray(ptr);
    end
    cyc0(C_NOP);
    checks++; if (if0.w_level !== 7'd0 || if0.w_full !== 1'b0 || if0.w_error !== 1'b0) begin
      errors++; $display("FAIL wrap_final: level %0d full %b err %b expected 0 0 0", if0.w_level, if0.w_full, if0.w_error); end
  endtask

  task automatic test_auto_drop();
    do_reset();
    for (int k = 1; k <= 44; k++) begin
      cyc0(C_WRITE);
      if (k == 39) begin
        checks++; if (if0.w_afull !== 1'b0 || if0.w_level !== 7'd39) begin
          errors++; $display("FAIL drop_afull39: afull %b level %0d expected 0 39", if0.w_afull, if0.w_level); end
      end
      if (k == 40) begin
        checks++; if (if0.w_afull !== 1'b1 || if0.w_full !== 1'b0) begin
          errors++; $display("FAIL drop_afull40: afull %b full %b expected 1 0", if0.w_afull, if0.w_full); end
      end
    end
    checks++; if (if0.w_full !== 1'b1 || if0.w_level !== 7'd44 || if0.w_frame_len !== 7'd44) begin
      errors++; $display("FAIL drop_full: full %b level %0d len %0d expected 1 44 44", if0.w_full, if0.w_level, if0.w_frame_len); end
    if0.w_cmd = C_WRITE;
    #1;
    checks++; if (if0.w_we !== 1'b0) begin errors++; $display("FAIL drop_blocked_we: got %b expected 0", if0.w_we); end
    @(posedge w_clk); #1;
    cyc0(C_WRITE);
    cyc0(C_EOF);
    checks++; if (if0.w_drop !== 1'b1 || if0.w_addr !== 6'd0) begin
      errors++; $display("FAIL drop_pulse: drop %b addr %0d expected 1 0", if0.w_drop, if0.w_addr); end
    checks++; if (if0.wptr !== gray(20)) begin errors++; $display("FAIL drop_wptr: got %0d expected %0d", if0.wptr, gray(20)); end
    @(posedge w_clk); #1;
    checks++; if (if0.w_drop !== 1'b0 || if0.w_level !== 7'd0 || if0.w_full !== 1'b0 || if0.w_frame_len !== 7'd0) begin
      errors++; $display("FAIL drop_after: drop %b level %0d full %b len %0d expected 0 0 0 0",
                         if0.w_drop, if0.w_level, if0.w_full, if0.w_frame_len); end
  endtask

  task automatic test_discard();
    do_reset();
    repeat (3) cyc2(C_WRITE);
    cyc2(C_EOF);
    cyc2(C_HEAD);
    cyc2(C_HEADL);
    checks++; if (if2.w_addr !== 6'd7) begin errors++; $display("FAIL disc_start_addr: got %0d expected 7", if2.w_addr); end
    repeat (7) cyc2(C_WRITE);
    checks++; if (if2.w_frame_len !== 7'd7 || if2.w_addr !== 6'd14) begin
      errors++; $display("FAIL disc_pre: len %0d addr %0d expected 7 14", if2.w_frame_len, if2.w_addr); end
    cyc2(C_DISC);
    checks++; if (if2.w_drop !== 1'b1 || if2.w_addr !== 6'd7 || if2.w_frame_len !== 7'd0) begin
      errors++; $display("FAIL disc_rewind: drop %b addr %0d len %0d expected 1 7 0", if2.w_drop, if2.w_addr, if2.w_frame_len); end
    if2.w_cmd = C_WRITE;
    #1;
    checks++; if (if2.w_we !== 1'b1 || if2.w_addr !== 6'd7) begin
      errors++; $display("FAIL disc_overwrite: we %b addr %0d expected 1 7", if2.w_we, if2.w_addr); end
    @(posedge w_clk); #1;
    if2.w_cmd = C_NOP;
    checks++; if (if2.w_drop !== 1'b0 || if2.w_frame_len !== 7'd1 || if2.w_addr !== 6'd8) begin
      errors++; $display("FAIL disc_after: drop %b len %0d addr %0d expected 0 1 8", if2.w_drop, if2.w_frame_len, if2.w_addr); end
    checks++; if (if2.wptr !== gray(25)) begin errors++; $display("FAIL disc_wptr: got %0d expected %0d", if2.wptr, gray(25)); end
  endtask

  task automatic test_reset_mid_heads();
    do_reset();
    cyc2(C_WRITE);
    cyc2(C_WRITE);
    cyc2(C_EOF);
    cyc2(C_HEAD);
    checks++; if (if2.w_addr !== 6'd1 || if2.w_frame_len !== 7'd2 || if2.w_level !== 7'd4) begin
      errors++; $display("FAIL midhead_pre: addr %0d len %0d level %0d expected 1 2 4", if2.w_addr, if2.w_frame_len, if2.w_level); end
    #2;
    w_rst_n = 1'b0;
    #1;
    checks++; if (if2.w_addr !== 6'd2 || if2.wptr !== gray(20) || if2.w_level !== 7'd0 || if2.w_frame_len !== 7'd0) begin
      errors++; $display("FAIL midhead_async: addr %0d wptr %0d level %0d len %0d expected 2 %0d 0 0",
                         if2.w_addr, if2.wptr, if2.w_level, if2.w_frame_len, gray(20)); end
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    checks++; if (if2.w_error !== 1'b0 || if0.w_error !== 1'b0) begin
      errors++; $display("FAIL err_clear: err2 %b err0 %b expected 0 0", if2.w_error, if0.w_error); end
    cyc2(C_RSVD);
    checks++; if (if2.w_error !== 1'b1) begin errors++; $display("FAIL err_rsvd: got %b expected 1", if2.w_error); end
    repeat (3) cyc2(C_NOP);
    checks++; if (if2.w_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", if2.w_error); end
    cyc0(C_HEAD);
    checks++; if (if0.w_error !== 1'b1) begin errors++; $display("FAIL err_head_hs0: got %b expected 1", if0.w_error); end
  endtask

  initial begin
    w_rst_n = 1'b1;
    if0.w_cmd = C_NOP;
    if2.w_cmd = C_NOP;
    if0.r2w_ptr = gray(20);
    if2.r2w_ptr = gray(20);
    test_reset();
    test_basic_frame();
    test_head_frame();
    test_wrap();
    test_auto_drop();
    test_discard();
    test_reset_mid_heads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
